// File: rtl/ampel_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ampel_pkg
//  Purpose  : Shared phase encoding, lamp colour codes and helper functions
//             for the pedestrian traffic-light controller.
//  Contents : phase_e      - controller phases
//             FARBE_*      - 2-bit lamp codes driven onto ampelfarbe
//             farbe_of()   - lamp code shown in a given phase
//             max_dauer()  - larger of two durations (timer sizing)
//  Revision : 1.0  initial release
// ============================================================================
package ampel_pkg;

  typedef enum logic [2:0] {
    GRUEN   = 3'd0,
    GELB    = 3'd1,
    ROT     = 3'd2,
    FUSS    = 3'd3,
    ROTGELB = 3'd4
  } phase_e;

  localparam logic [1:0] FARBE_GRUEN   = 2'b00;
  localparam logic [1:0] FARBE_GELB    = 2'b01;
  localparam logic [1:0] FARBE_ROT     = 2'b10;
  localparam logic [1:0] FARBE_ROTGELB = 2'b11;

  // The pedestrian phase keeps the vehicle lamp on red.
  function automatic logic [1:0] farbe_of(input phase_e phase);
    logic [1:0] farbe;
    farbe = FARBE_GRUEN;
    case (phase)
      GRUEN:   farbe = FARBE_GRUEN;
      GELB:    farbe = FARBE_GELB;
      ROT:     farbe = FARBE_ROT;
      FUSS:    farbe = FARBE_ROT;
      ROTGELB: farbe = FARBE_ROTGELB;
      default: farbe = FARBE_GRUEN;
    endcase
    return farbe;
  endfunction

  function automatic int unsigned max_dauer(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ampel_phasen_timer.sv
`default_nettype none
// ============================================================================
//  Module   : ampel_phasen_timer
//  Purpose  : Phase timer. Counts enabled ticks; a synchronous clear returns
//             it to zero on every phase change.
//  Ports    : clk    in   clock
//             rst    in   asynchronous active-high reset
//             en_i   in   count enable (phase tick)
//             clr_i  in   synchronous clear, has priority over en_i
//             count  out  WIDTH-bit tick count within the current phase
//  Revision : 1.0  initial release
// ============================================================================
module ampel_phasen_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/ampel_fussgaenger_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ampel_fussgaenger_ctrl
//  Purpose  : Self-timed traffic-light controller with pedestrian request.
//             Phases GRUEN -> GELB -> ROT -> [FUSS] -> ROTGELB -> GRUEN,
//             each lasting a configurable number of takt_en ticks. A pending
//             request may cut green short after T_GRUEN_MIN ticks and inserts
//             the pedestrian phase FUSS after the next red.
//  Ports    : clk               in   clock
//             rst               in   asynchronous active-high reset
//             takt_en           in   phase tick, timers advance only when 1
//             knopf             in   pedestrian button (level)
//             ampelfarbe        out  00 green, 01 yellow, 10 red, 11 red-yellow
//             fussgaenger_gruen out  pedestrian walk signal (FUSS only)
//             wunsch            out  pedestrian request pending
//  Revision : 1.0  initial release
// ============================================================================
module ampel_fussgaenger_ctrl #(
  parameter int unsigned T_GRUEN     = 6,
  parameter int unsigned T_GRUEN_MIN = 2,
  parameter int unsigned T_GELB      = 1,
  parameter int unsigned T_ROT       = 3,
  parameter int unsigned T_FUSS      = 4,
  parameter int unsigned T_ROTGELB   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       takt_en,
  input  logic       knopf,
  output logic [1:0] ampelfarbe,
  output logic       fussgaenger_gruen,
  output logic       wunsch
);

  import ampel_pkg::*;

  localparam int unsigned T_MAX = max_dauer(max_dauer(max_dauer(T_GRUEN, T_GELB),
                                                      max_dauer(T_ROT, T_FUSS)),
                                            T_ROTGELB);
  localparam int unsigned TW = $clog2(T_MAX) + 1;

  // Timer value on the last tick of each phase.
  localparam logic [TW-1:0] c_gruen_last     = TW'(T_GRUEN - 1);
  localparam logic [TW-1:0] c_gruen_min_last = TW'(T_GRUEN_MIN - 1);
  localparam logic [TW-1:0] c_gelb_last      = TW'(T_GELB - 1);
  localparam logic [TW-1:0] c_rot_last       = TW'(T_ROT - 1);
  localparam logic [TW-1:0] c_fuss_last      = TW'(T_FUSS - 1);
  localparam logic [TW-1:0] c_rotgelb_last   = TW'(T_ROTGELB - 1);

  phase_e          state_q, state_d;
  logic            wunsch_q, wunsch_d;
  logic [1:0]      farbe_q, farbe_d;
  logic            fuss_q, fuss_d;
  logic            wechsel_d;
  logic [TW-1:0]   count;

  ampel_phasen_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .en_i  (takt_en),
    .clr_i (wechsel_d),
    .count (count)
  );

  // Next phase, request latch and lamp decode. Lamp outputs are decoded from
  // the next state and registered, so they change together with the phase.
  always_comb begin
    state_d = state_q;
    if (takt_en) begin
      case (state_q)
        GRUEN: begin
          if ((count == c_gruen_last) ||
              (wunsch_q && (count >= c_gruen_min_last))) begin
            state_d = GELB;
          end
        end
        GELB: begin
          if (count == c_gelb_last) state_d = ROT;
        end
        ROT: begin
          if (count == c_rot_last) state_d = wunsch_q ? FUSS : ROTGELB;
        end
        FUSS: begin
          if (count == c_fuss_last) state_d = ROTGELB;
        end
        ROTGELB: begin
          if (count == c_rotgelb_last) state_d = GRUEN;
        end
        default: state_d = GRUEN;
      endcase
    end

    // Every transition changes the phase, so a phase change clears the timer.
    wechsel_d = (state_d != state_q);

    wunsch_d = wunsch_q;
    if (knopf && (state_q != FUSS)) begin
      wunsch_d = 1'b1;
    end
    // Entering FUSS serves the request; this beats a press on the same clock.
    if ((state_q == ROT) && (state_d == FUSS)) begin
      wunsch_d = 1'b0;
    end

    farbe_d = farbe_of(state_d);
    fuss_d  = (state_d == FUSS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= GRUEN;
      wunsch_q <= 1'b0;
      farbe_q  <= FARBE_GRUEN;
      fuss_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wunsch_q <= wunsch_d;
      farbe_q  <= farbe_d;
      fuss_q   <= fuss_d;
    end
  end

  assign ampelfarbe        = farbe_q;
  assign fussgaenger_gruen = fuss_q;
  assign wunsch            = wunsch_q;

endmodule
`default_nettype wire
